// File: rtl/rf_wrport_arbiter_if.sv
// Register-file write-port arbitration bundle: writeback request, mul/div result
// stream, decode read addresses for hazard checks, and the reg_array write port.
interface rf_wrport_arbiter_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          pause;
   logic          wb_wren;
   logic [4:0]    wb_addr;
   logic [31:0]   wb_data;
   logic          md_valid;
   logic [4:0]    md_addr;
   logic [31:0]   md_data;
   logic          md_ready;
   logic [4:0]    rs_addr;
   logic [4:0]    rt_addr;
   logic          raw_hazard;
   logic          wb_stall;
   logic          rf_wren;
   logic [4:0]    rf_wraddress;
   logic [31:0]   rf_data;
   logic [CW-1:0] fifo_count;

   modport master (
      output pause, wb_wren, wb_addr, wb_data, md_valid, md_addr, md_data, rs_addr, rt_addr,
      input  md_ready, raw_hazard, wb_stall, rf_wren, rf_wraddress, rf_data, fifo_count
   );

   modport slave (
      input  pause, wb_wren, wb_addr, wb_data, md_valid, md_addr, md_data, rs_addr, rt_addr,
      output md_ready, raw_hazard, wb_stall, rf_wren, rf_wraddress, rf_data, fifo_count
   );
endinterface

// File: rtl/rf_wrport_arbiter.sv
// Shares the register-file write port between in-order writeback and a FIFO of
// out-of-order mul/div results, with starvation stall and RAW hazard detection.
module rf_wrport_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   rf_wrport_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [4:0]    r_mem_addr [DEPTH];
   logic [31:0]   r_mem_data [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_starve_cnt;

   logic w_empty;
   logic w_full;
   logic w_starve;
   logic w_wb_live;
   logic w_grant_fifo;
   logic w_push;
   logic w_store;
   logic w_pop;
   logic w_hazard;

   assign w_empty   = (r_count == {CW{1'b0}});
   assign w_full    = (r_count == FULL_CNT);
   assign w_starve  = ~w_empty & (r_starve_cnt >= STARVE_LIM);
   assign w_wb_live = bus.wb_wren & (bus.wb_addr != 5'd0);

   // md_ready is based on the registered count only, so a full FIFO never accepts on its pop cycle
   assign bus.md_ready   = ~i_rst & ~w_full;
   assign bus.raw_hazard = ~i_rst & w_hazard;
   assign bus.fifo_count = i_rst ? {CW{1'b0}} : r_count;

   assign w_push  = bus.md_valid & bus.md_ready;
   assign w_store = w_push & (bus.md_addr != 5'd0);
   assign w_pop   = w_grant_fifo & ~bus.pause;

   // Write-port grant: starved FIFO head, then live writeback, then FIFO head in an idle slot
   always_comb begin
      w_grant_fifo     = 1'b0;
      bus.wb_stall     = 1'b0;
      bus.rf_wren      = 1'b0;
      bus.rf_wraddress = 5'd0;
      bus.rf_data      = 32'd0;
      if (i_rst) begin
         w_grant_fifo = 1'b0;
      end else if (w_starve) begin
         w_grant_fifo     = 1'b1;
         bus.wb_stall     = 1'b1;
         bus.rf_wren      = 1'b1;
         bus.rf_wraddress = r_mem_addr[r_rd_ptr];
         bus.rf_data      = r_mem_data[r_rd_ptr];
      end else if (w_wb_live) begin
         bus.rf_wren      = 1'b1;
         bus.rf_wraddress = bus.wb_addr;
         bus.rf_data      = bus.wb_data;
      end else if (!w_empty) begin
         w_grant_fifo     = 1'b1;
         bus.rf_wren      = 1'b1;
         bus.rf_wraddress = r_mem_addr[r_rd_ptr];
         bus.rf_data      = r_mem_data[r_rd_ptr];
      end else begin
         w_grant_fifo = 1'b0;
      end
   end

   // RAW hazard: any valid entry (head included, even if popping now) targeting rs/rt
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < r_count) begin
            if (((r_mem_addr[r_rd_ptr + AW'(i)] == bus.rs_addr) && (bus.rs_addr != 5'd0)) ||
                ((r_mem_addr[r_rd_ptr + AW'(i)] == bus.rt_addr) && (bus.rt_addr != 5'd0))) begin
               w_hazard = 1'b1;
            end else begin
               w_hazard = w_hazard;
            end
         end else begin
            w_hazard = w_hazard;
         end
      end
   end

   // FIFO storage; r0 results are accepted but never stored
   always_ff @(posedge i_clk) begin
      if (w_store) begin
         r_mem_addr[r_wr_ptr] <= bus.md_addr;
         r_mem_data[r_wr_ptr] <= bus.md_data;
      end
   end

   // Pointers, occupancy and starvation counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr     <= {AW{1'b0}};
         r_wr_ptr     <= {AW{1'b0}};
         r_count      <= {CW{1'b0}};
         r_starve_cnt <= {SW{1'b0}};
      end else begin
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_store) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_store) - CW'(w_pop);
         if (bus.pause) begin
            r_starve_cnt <= r_starve_cnt;
         end else if (w_empty || w_grant_fifo) begin
            r_starve_cnt <= {SW{1'b0}};
         end else if (r_starve_cnt < STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
         end else begin
            r_starve_cnt <= r_starve_cnt;
         end
      end
   end
endmodule

// File: tb/tb_rf_wrport_arbiter.sv
// Self-checking bench: directed vector table, hand-written fill/starvation sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rf_wrport_arbiter;
   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   typedef struct {
      logic        rst, pause, wb_wren;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        md_valid;
      logic [4:0]  md_addr;
      logic [31:0] md_data;
      logic [4:0]  rs, rt;
   } in_t;

   typedef struct {
      in_t         i;
      logic        e_wren;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        e_stall, e_rdy;
      logic [2:0]  e_cnt;
      logic        e_hz;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   ent_t q[$];
   int   scnt = 0;

   logic        o_wren, o_stall, o_rdy, o_hz;
   logic [4:0]  o_addr;
   logic [31:0] o_data;
   logic [2:0]  o_cnt;

   rf_wrport_arbiter_if #(.DEPTH(DEPTH)) bus ();

   rf_wrport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mki(input logic r, p, ww, input logic [4:0] wa, input logic [31:0] wd,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic [4:0] rs, rt);
      in_t v;
      v.rst = r; v.pause = p; v.wb_wren = ww; v.wb_addr = wa; v.wb_data = wd;
      v.md_valid = mv; v.md_addr = ma; v.md_data = md; v.rs = rs; v.rt = rt;
      return v;
   endfunction

   function automatic vec_t mkv(input in_t i, input logic ew, input logic [4:0] ea,
                                input logic [31:0] ed, input logic es, er,
                                input logic [2:0] ec, input logic eh);
      vec_t v;
      v.i = i; v.e_wren = ew; v.e_addr = ea; v.e_data = ed;
      v.e_stall = es; v.e_rdy = er; v.e_cnt = ec; v.e_hz = eh;
      return v;
   endfunction

   // One cycle: drive at negedge, check against the reference model, advance the model.
   task automatic step(input in_t v);
      bit          ne, starve, live, gf, xw, xs, xh, xr, rdy;
      logic [4:0]  xa;
      logic [31:0] xd;
      int          xc;
      @(negedge clk);
      rst          = v.rst;
      bus.pause    = v.pause;
      bus.wb_wren  = v.wb_wren;
      bus.wb_addr  = v.wb_addr;
      bus.wb_data  = v.wb_data;
      bus.md_valid = v.md_valid;
      bus.md_addr  = v.md_addr;
      bus.md_data  = v.md_data;
      bus.rs_addr  = v.rs;
      bus.rt_addr  = v.rt;
      #1;
      xw = 0; xa = 5'd0; xd = 32'd0; xs = 0; xh = 0; gf = 0; xr = 0; xc = 0;
      ne = q.size() > 0;
      if (!v.rst) begin
         starve = ne && (scnt >= STARVE_MAX);
         live   = v.wb_wren && (v.wb_addr != 5'd0);
         xr     = q.size() < DEPTH;
         xc     = q.size();
         if (starve || (!live && ne)) begin
            gf = 1; xw = 1; xs = starve; xa = q[0].addr; xd = q[0].data;
         end else if (live) begin
            xw = 1; xa = v.wb_addr; xd = v.wb_data;
         end
         foreach (q[k])
            if ((q[k].addr == v.rs && v.rs != 5'd0) || (q[k].addr == v.rt && v.rt != 5'd0))
               xh = 1;
      end
      chk("mdl.rf_wren", bus.rf_wren, xw);
      chk("mdl.rf_wraddress", bus.rf_wraddress, xa);
      chk("mdl.rf_data", bus.rf_data, xd);
      chk("mdl.wb_stall", bus.wb_stall, xs);
      chk("mdl.md_ready", bus.md_ready, xr);
      chk("mdl.fifo_count", bus.fifo_count, xc);
      chk("mdl.raw_hazard", bus.raw_hazard, xh);
      o_wren = bus.rf_wren; o_addr = bus.rf_wraddress; o_data = bus.rf_data;
      o_stall = bus.wb_stall; o_rdy = bus.md_ready; o_cnt = bus.fifo_count; o_hz = bus.raw_hazard;
      if (v.rst) begin
         q.delete();
         scnt = 0;
      end else begin
         rdy = q.size() < DEPTH;
         if (!v.pause) begin
            if (!ne || gf) scnt = 0;
            else if (scnt < STARVE_MAX) scnt++;
         end
         if (gf && !v.pause) void'(q.pop_front());
         if (v.md_valid && rdy && v.md_addr != 5'd0) q.push_back('{v.md_addr, v.md_data});
      end
      @(posedge clk);
   endtask

   vec_t tbl[15];
   in_t  idle_v;
   in_t  r_v;
   bit   seen;

   initial begin
      idle_v = mki(0,0, 0,5'd0,32'd0, 0,5'd0,32'd0, 5'd0,5'd0);
      tbl[0]  = mkv(mki(1,0, 0,5'd0,32'd0, 0,5'd0,32'd0, 5'd0,5'd0),                0,5'd0,32'd0,0,0,3'd0,0);
      tbl[1]  = tbl[0];
      tbl[2]  = mkv(idle_v,                                                         0,5'd0,32'd0,0,1,3'd0,0);
      tbl[3]  = mkv(mki(0,0, 0,5'd0,32'd0, 1,5'd5,32'hDEADBEEF, 5'd0,5'd0),         0,5'd0,32'd0,0,1,3'd0,0);
      tbl[4]  = mkv(mki(0,0, 0,5'd0,32'd0, 0,5'd0,32'd0, 5'd5,5'd0),                1,5'd5,32'hDEADBEEF,0,1,3'd1,1);
      tbl[5]  = mkv(mki(0,0, 0,5'd0,32'd0, 0,5'd0,32'd0, 5'd5,5'd0),                0,5'd0,32'd0,0,1,3'd0,0);
      tbl[6]  = mkv(mki(0,0, 1,5'd3,32'h33, 1,5'd9,32'h99, 5'd0,5'd0),              1,5'd3,32'h33,0,1,3'd0,0);
      tbl[7]  = mkv(mki(0,0, 1,5'd0,32'h55, 0,5'd0,32'd0, 5'd9,5'd0),               1,5'd9,32'h99,0,1,3'd1,1);
      tbl[8]  = mkv(mki(0,0, 0,5'd0,32'd0, 1,5'd0,32'h77, 5'd0,5'd9),               0,5'd0,32'd0,0,1,3'd0,0);
      tbl[9]  = mkv(idle_v,                                                         0,5'd0,32'd0,0,1,3'd0,0);
      tbl[10] = mkv(mki(0,1, 0,5'd0,32'd0, 1,5'd10,32'hA, 5'd0,5'd0),               0,5'd0,32'd0,0,1,3'd0,0);
      tbl[11] = mkv(mki(0,1, 0,5'd0,32'd0, 1,5'd11,32'hB, 5'd0,5'd0),               1,5'd10,32'hA,0,1,3'd1,0);
      tbl[12] = mkv(mki(0,1, 0,5'd0,32'd0, 1,5'd12,32'hC, 5'd11,5'd0),              1,5'd10,32'hA,0,1,3'd2,1);
      tbl[13] = tbl[0];
      tbl[14] = tbl[2];

      for (int n = 0; n < 15; n++) begin
         step(tbl[n].i);
         chk($sformatf("tbl%0d.rf_wren", n), o_wren, tbl[n].e_wren);
         chk($sformatf("tbl%0d.rf_wraddress", n), o_addr, tbl[n].e_addr);
         chk($sformatf("tbl%0d.rf_data", n), o_data, tbl[n].e_data);
         chk($sformatf("tbl%0d.wb_stall", n), o_stall, tbl[n].e_stall);
         chk($sformatf("tbl%0d.md_ready", n), o_rdy, tbl[n].e_rdy);
         chk($sformatf("tbl%0d.fifo_count", n), o_cnt, tbl[n].e_cnt);
         chk($sformatf("tbl%0d.raw_hazard", n), o_hz, tbl[n].e_hz);
      end

      // Fill to full while writeback occupies the port every cycle
      for (int k = 0; k < 4; k++)
         step(mki(0,0, 1,5'(k+1),32'(k), 1,5'(16+k),32'(256+k), 5'd0,5'd0));
      step(mki(0,0, 1,5'd8,32'h8, 1,5'd20,32'h120, 5'd0,5'd0));
      chk("fill.fifo_count", o_cnt, 3'd4);
      chk("fill.md_ready", o_rdy, 1'b0);
      step(mki(0,0, 0,5'd0,32'd0, 1,5'd20,32'h120, 5'd0,5'd0));
      chk("fill.pop_addr", o_addr, 5'd16);
      chk("fill.pop_ready", o_rdy, 1'b0);
      step(mki(0,0, 0,5'd0,32'd0, 1,5'd20,32'h120, 5'd0,5'd0));
      chk("fill.reopen_ready", o_rdy, 1'b1);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step(idle_v);
         if (o_wren && o_addr == 5'd20 && o_data == 32'h120) seen = 1;
      end
      chk("fill.fifth_written", seen, 1'b1);

      // Starvation: one entry behind continuous writeback
      step(mki(1,0, 0,5'd0,32'd0, 0,5'd0,32'd0, 5'd0,5'd0));
      step(mki(0,0, 1,5'd7,32'h11, 1,5'd6,32'h66, 5'd0,5'd0));
      for (int c = 1; c <= 10; c++) begin
         step(mki(0,0, 1,5'd7,32'h11, 0,5'd0,32'd0, 5'd0,5'd0));
         if (c <= 8) begin
            chk($sformatf("starve.c%0d.stall", c), o_stall, 1'b0);
            chk($sformatf("starve.c%0d.addr", c), o_addr, 5'd7);
         end else if (c == 9) begin
            chk("starve.stall", o_stall, 1'b1);
            chk("starve.head_addr", o_addr, 5'd6);
            chk("starve.head_data", o_data, 32'h66);
         end else begin
            chk("starve.after_stall", o_stall, 1'b0);
            chk("starve.wb_addr", o_addr, 5'd7);
            chk("starve.wb_data", o_data, 32'h11);
            chk("starve.count", o_cnt, 3'd0);
         end
      end

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         r_v.rst      = ($urandom_range(0, 99) == 0);
         r_v.pause    = ($urandom_range(0, 7) == 0);
         r_v.wb_wren  = ($urandom_range(0, 2) == 0);
         r_v.wb_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         r_v.wb_data  = $urandom;
         r_v.md_valid = $urandom_range(0, 1) != 0;
         r_v.md_addr  = 5'($urandom_range(0, 7));
         r_v.md_data  = $urandom;
         r_v.rs       = 5'($urandom_range(0, 7));
         r_v.rt       = 5'($urandom_range(0, 7));
         step(r_v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
